// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a conversion controller and bin2bcd_seq.
// The controller drives start/bin; the converter returns busy/done/bcd.
interface bin2bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// IDLE captures the operand on start, SHIFT runs W adjust+shift steps,
// DONE publishes the scratch digits to the registered bcd output.
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic    clk,
    input  logic    rst,
    bin2bcd_if.slave bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_bin;
    logic [SW-1:0]  r_scratch;
    logic [SW-1:0]  r_bcd;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    logic           w_accept;
    logic           w_shift;
    logic           w_publish;
    logic           w_busy_nxt;
    logic [SW-1:0]  w_adj;
    logic [SW+W-1:0] w_cat;

    // Add 3 to every digit that is 5 or more, so the following doubling
    // carries correctly into the next decimal digit.
    function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign w_adj = add3_digits(r_scratch);
    assign w_cat = {w_adj, r_bin} << 1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_publish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_publish   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // busy covers the whole conversion including the cycle done is shown.
        w_busy_nxt = w_accept || (r_state != S_IDLE);
    end

    // Operand/scratch/counter datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_publish;
            if (w_accept) begin
                r_bin     <= bus.bin;
                r_scratch <= '0;
                r_cnt     <= '0;
            end else if (w_shift) begin
                r_scratch <= w_cat[SW+W-1:W];
                r_bin     <= w_cat[W-1:0];
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_publish) begin
                r_bcd <= r_scratch;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with W=8, DIGITS=3.
module tb_bin2bcd_seq;
    localparam int W      = 8;
    localparam int DIGITS = 3;

    if (10**DIGITS <= 2**W - 1) begin : g_bad_params
        $error("DIGITS too small for W");
    end

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bin2bcd_if #(.W(W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and wait (bounded) for done.
    // lat = edges after the start edge until done is visible (0 = timeout).
    task automatic run_conv(input logic [7:0] v, output int lat,
                            output logic [11:0] res, output logic done_after,
                            output logic busy_after);
        bus.start = 1'b1;
        bus.bin   = v;
        lat = 0;
        res = 12'hfff;
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c - 1;
                res = bus.bcd;
                break;
            end
        end
        tick();
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bin = '0;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++;
        if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", bus.bcd); end
    endtask

    task automatic test_zero();
        int lat; logic [11:0] res; logic da, ba;
        run_conv(8'd0, lat, res, da, ba);
        n_tests++;
        if (lat !== 9) begin n_fail++; $display("FAIL zero_latency: got %0d expected 9", lat); end
        n_tests++;
        if (res !== 12'h000) begin n_fail++; $display("FAIL zero_bcd: got %h expected 000", res); end
        n_tests++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", da); end
        n_tests++;
        if (ba !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b expected 0", ba); end
    endtask

    task automatic test_directed();
        logic [7:0]  vin [4];
        logic [11:0] vexp [4];
        int lat; logic [11:0] res; logic da, ba;
        vin[0] = 8'd255; vexp[0] = 12'h255;
        vin[1] = 8'd99;  vexp[1] = 12'h099;
        vin[2] = 8'd100; vexp[2] = 12'h100;
        vin[3] = 8'd9;   vexp[3] = 12'h009;
        for (int i = 0; i < 4; i++) begin
            run_conv(vin[i], lat, res, da, ba);
            n_tests++;
            if (res !== vexp[i]) begin n_fail++; $display("FAIL directed_bcd bin=%0d: got %h expected %h", vin[i], res, vexp[i]); end
            n_tests++;
            if (lat !== 9) begin n_fail++; $display("FAIL directed_latency bin=%0d: got %0d expected 9", vin[i], lat); end
        end
    endtask

    task automatic test_sweep();
        int lat; logic [11:0] res; logic da, ba;
        logic [11:0] exp_v;
        for (int v = 0; v < 256; v++) begin
            exp_v[11:8] = 4'(v / 100);
            exp_v[7:4]  = 4'((v / 10) % 10);
            exp_v[3:0]  = 4'(v % 10);
            run_conv(8'(v), lat, res, da, ba);
            n_tests++;
            if (res !== exp_v) begin n_fail++; $display("FAIL sweep_bcd bin=%0d: got %h expected %h", v, res, exp_v); end
            n_tests++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL sweep_done_width bin=%0d: got %b expected 0", v, da); end
        end
    endtask

    task automatic test_ignore_start();
        int nd; int dc; logic [11:0] res;
        nd = 0; dc = 0; res = 12'hfff;
        bus.start = 1'b1; bus.bin = 8'd200;
        tick();
        bus.start = 1'b0; bus.bin = 8'd99;
        tick();
        bus.start = 1'b1; bus.bin = 8'd17;
        tick();
        bus.start = 1'b0;
        for (int c = 4; c <= 25; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                nd++;
                dc = c - 1;
                res = bus.bcd;
            end
        end
        n_tests++;
        if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
        n_tests++;
        if (res !== 12'h200) begin n_fail++; $display("FAIL ignore_bcd: got %h expected 200", res); end
        n_tests++;
        if (dc !== 9) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 9", dc); end
    endtask

    task automatic test_abort();
        int lat; logic [11:0] res; logic da, ba; int nd;
        run_conv(8'd42, lat, res, da, ba);
        n_tests++;
        if (res !== 12'h042) begin n_fail++; $display("FAIL abort_prior: got %h expected 042", res); end
        bus.start = 1'b1; bus.bin = 8'd123;
        tick();
        bus.start = 1'b0;
        n_tests++;
        if (bus.bcd !== 12'h042) begin n_fail++; $display("FAIL abort_bcd_hold: got %h expected 042", bus.bcd); end
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd: got %h expected 000", bus.bcd); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        nd = (bus.done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        n_tests++;
        if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
        run_conv(8'd123, lat, res, da, ba);
        n_tests++;
        if (res !== 12'h123) begin n_fail++; $display("FAIL abort_rerun: got %h expected 123", res); end
    endtask

    task automatic test_back_to_back();
        int nd; int prev;
        nd = 0; prev = 0;
        bus.start = 1'b1; bus.bin = 8'd57;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                nd++;
                n_tests++;
                if (bus.bcd !== 12'h057) begin n_fail++; $display("FAIL b2b_bcd: got %h expected 057", bus.bcd); end
                if (nd > 1) begin
                    n_tests++;
                    if (c - prev !== 10) begin n_fail++; $display("FAIL b2b_period: got %0d expected 10", c - prev); end
                end
                prev = c;
            end
        end
        n_tests++;
        if (nd !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 4", nd); end
        bus.start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bin = '0;
        test_reset();
        test_zero();
        test_directed();
        test_sweep();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
